// File: rtl/if_id_queue_if.sv
// Fetch-to-decode queue bus: push side from fetch, pop side to decode,
// plus flush control and status. The queue itself uses the slave modport.
interface if_id_queue_if;
    logic        flush;
    logic        if_valid;
    logic [15:0] if_pc;
    logic [15:0] if_instr;
    logic        if_ready;
    logic        id_ready;
    logic        id_valid;
    logic [15:0] id_pc;
    logic [15:0] id_pc_next;
    logic [15:0] id_instr;
    logic [3:0]  occupancy;
    logic [7:0]  flush_drops;

    modport master (
        output flush, if_valid, if_pc, if_instr, id_ready,
        input  if_ready, id_valid, id_pc, id_pc_next, id_instr, occupancy, flush_drops
    );

    modport slave (
        input  flush, if_valid, if_pc, if_instr, id_ready,
        output if_ready, id_valid, id_pc, id_pc_next, id_instr, occupancy, flush_drops
    );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: small circular FIFO between fetch and decode.
// Handshakes depend only on the registered count (no full pass-through,
// no empty bypass). Flush empties the queue and accumulates a saturating
// count of discarded entries. Reset is synchronous, active-low.
module if_id_queue #(
    parameter int DEPTH = 4          // 2, 4 or 8
) (
    input  logic          clk,
    input  logic          rst,
    if_id_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [3:0]    r_count;
    logic [7:0]    r_flush_drops;
    logic          r_run;          // low for reset and the first cycle after release

    logic [15:0]   r_pc_mem    [DEPTH];
    logic [15:0]   r_instr_mem [DEPTH];

    logic          w_active;
    logic          w_if_ready;
    logic          w_id_valid;
    logic          w_push;
    logic          w_pop;
    logic [15:0]   w_head_pc;
    logic [15:0]   w_head_instr;
    logic [8:0]    w_drops_sum;

    assign w_active     = rst & r_run & ~bus.flush;
    assign w_if_ready   = w_active & (r_count < 4'(DEPTH));
    assign w_id_valid   = w_active & (r_count != 4'd0);
    assign w_push       = bus.if_valid & w_if_ready;
    assign w_pop        = w_id_valid & bus.id_ready;
    assign w_head_pc    = r_pc_mem[r_rd_ptr];
    assign w_head_instr = r_instr_mem[r_rd_ptr];
    assign w_drops_sum  = 9'(r_flush_drops) + 9'(r_count);

    assign bus.if_ready    = w_if_ready;
    assign bus.id_valid    = w_id_valid;
    // Head outputs are forced to zero when invalid so stale or X storage never leaks out.
    assign bus.id_pc       = w_id_valid ? w_head_pc           : 16'h0000;
    assign bus.id_instr    = w_id_valid ? w_head_instr        : 16'h0000;
    assign bus.id_pc_next  = w_id_valid ? (w_head_pc + 16'd1) : 16'h0000;
    assign bus.occupancy   = r_count;
    assign bus.flush_drops = r_flush_drops;

    // Run flag: holds the handshakes off for one cycle after reset release.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    // Pointers and count; flush outranks push/pop, reset outranks everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 4'd0;
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 4'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + 4'(w_push) - 4'(w_pop);
        end
    end

    // Saturating tally of entries thrown away by flushes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_flush_drops <= 8'd0;
        end else if (bus.flush) begin
            r_flush_drops <= w_drops_sum[8] ? 8'hFF : w_drops_sum[7:0];
        end
    end

    // Per-entry storage; written only on an accepted push, never reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Capture the fetched PC/instruction when this slot is the write target.
            always_ff @(posedge clk) begin
                if (w_push && (r_wr_ptr == PW'(gi))) begin
                    r_pc_mem[gi]    <= bus.if_pc;
                    r_instr_mem[gi] <= bus.if_instr;
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue (DEPTH=4): table of per-cycle stimulus with
// hand-derived occupancy, a queue scoreboard for head contents, and
// hand-written reset / flush-saturation sequences.
module tb_if_id_queue;
    localparam int DEPTH = 4;

    typedef struct {
        bit          fl;
        bit          v;
        logic [15:0] pc;
        logic [15:0] instr;
        bit          rdy;
        int          occ;
    } vec_t;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    if_id_queue_if bus();

    if_id_queue #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    ent_t m_q[$];
    int   m_drops  = 0;
    bit   m_run    = 1'b0;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, check pre-edge outputs against the scoreboard, advance.
    task automatic cycle(input bit fl, input bit v, input logic [15:0] pc,
                         input logic [15:0] ins, input bit rdy);
        bit          act_en;
        bit          e_ir;
        bit          e_iv;
        ent_t        h;
        ent_t        e;
        logic [15:0] nx;
        bus.flush    = fl;
        bus.if_valid = v;
        bus.if_pc    = pc;
        bus.if_instr = ins;
        bus.id_ready = rdy;
        #1;
        act_en = rst && m_run && !fl;
        e_ir   = act_en && (m_q.size() < DEPTH);
        e_iv   = act_en && (m_q.size() > 0);
        check("if_ready", bus.if_ready, e_ir);
        check("id_valid", bus.id_valid, e_iv);
        check("occupancy", bus.occupancy, m_q.size());
        check("flush_drops", bus.flush_drops, m_drops);
        if (e_iv) begin
            h  = m_q[0];
            nx = h.pc + 16'd1;
            check("id_pc", bus.id_pc, h.pc);
            check("id_instr", bus.id_instr, h.instr);
            check("id_pc_next", bus.id_pc_next, nx);
        end else begin
            check("id_pc_zero", bus.id_pc, 16'h0000);
            check("id_instr_zero", bus.id_instr, 16'h0000);
            check("id_pc_next_zero", bus.id_pc_next, 16'h0000);
        end
        if (!rst) begin
            m_q.delete();
            m_drops = 0;
            m_run   = 1'b0;
        end else begin
            m_run = 1'b1;
            if (fl) begin
                m_drops = (m_drops + m_q.size() > 255) ? 255 : m_drops + m_q.size();
                m_q.delete();
            end else begin
                if (e_iv && rdy) void'(m_q.pop_front());
                if (v && e_ir) begin
                    e.pc    = pc;
                    e.instr = ins;
                    m_q.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic add(input bit fl, input bit v, input logic [15:0] pc,
                       input logic [15:0] ins, input bit rdy, input int occ);
        vec_t r;
        r.fl = fl; r.v = v; r.pc = pc; r.instr = ins; r.rdy = rdy; r.occ = occ;
        vecs.push_back(r);
    endtask

    initial begin
        bus.flush = 0; bus.if_valid = 0; bus.if_pc = 0; bus.if_instr = 0; bus.id_ready = 0;

        // Vector table: {flush, if_valid, pc, instr, id_ready, occupancy after edge}
        add(0, 1, 16'h0010, 16'hA5A5, 0, 1);           // single push
        add(0, 0, 16'h0000, 16'h0000, 1, 0);           // pop it
        for (int i = 0; i < 5; i++)                    // fill; 5th push ignored
            add(0, 1, 16'(i), 16'h1000 + 16'(i), 0, (i + 1 > 4) ? 4 : i + 1);
        add(0, 1, 16'h0005, 16'h1005, 1, 3);           // full + pop: pop only
        add(0, 1, 16'h0006, 16'h1006, 0, 4);           // push accepted next cycle
        for (int i = 3; i >= 0; i--)
            add(0, 0, 16'h0000, 16'h0000, 1, i);
        add(0, 1, 16'hFFF8, 16'h2000, 0, 1);           // wrap-around run
        for (int k = 1; k < 10; k++)
            add(0, 1, 16'hFFF8 + 16'(k), 16'h2000 + 16'(k), 1, 1);
        add(0, 0, 16'h0000, 16'h0000, 1, 0);
        for (int i = 1; i <= 3; i++)                   // flush with push+pop pending
            add(0, 1, 16'h0100 + 16'(i), 16'h3000 + 16'(i), 0, i);
        add(1, 1, 16'h0BAD, 16'hBAD0, 1, 0);
        add(0, 0, 16'h0000, 16'h0000, 0, 0);
        add(0, 0, 16'h1234, 16'hDEAD, 1, 0);           // if_valid=0 never stores
        add(0, 1, 16'h0042, 16'h4242, 1, 1);
        add(0, 0, 16'h0000, 16'h0000, 1, 0);

        // Reset and first cycle after release
        rst = 1'b0;
        cycle(0, 1, 16'h0001, 16'h0001, 1);
        cycle(0, 1, 16'h0002, 16'h0002, 1);
        rst = 1'b1;
        cycle(0, 1, 16'h0003, 16'h0003, 1);
        check("occ_after_reset", bus.occupancy, 4'd0);

        foreach (vecs[i]) begin
            cycle(vecs[i].fl, vecs[i].v, vecs[i].pc, vecs[i].instr, vecs[i].rdy);
            check("vec_occupancy", bus.occupancy, vecs[i].occ);
            $display("vec %0d: flush=%0d v=%0d pc=%h rdy=%0d occ=%0d drops=%0d",
                     i, vecs[i].fl, vecs[i].v, vecs[i].pc, vecs[i].rdy, bus.occupancy, bus.flush_drops);
        end
        check("drops_after_flush", bus.flush_drops, 8'd3);

        // Reset mid-operation with a push pending
        cycle(0, 1, 16'h0500, 16'h5500, 0);
        cycle(0, 1, 16'h0501, 16'h5501, 0);
        check("occ_before_rst", bus.occupancy, 4'd2);
        rst = 1'b0;
        cycle(0, 1, 16'h0502, 16'h5502, 0);
        check("rst_occ", bus.occupancy, 4'd0);
        check("rst_drops", bus.flush_drops, 8'd0);
        rst = 1'b1;
        cycle(0, 1, 16'h0503, 16'h5503, 0);            // if_ready still 0 here
        check("rst_release_occ", bus.occupancy, 4'd0);
        cycle(0, 1, 16'h0504, 16'h5504, 0);            // now accepted
        check("rst_release_push", bus.occupancy, 4'd1);
        $display("reset sequence: occ=%0d drops=%0d", bus.occupancy, bus.flush_drops);
        cycle(0, 0, 16'h0000, 16'h0000, 1);

        // Saturation of flush_drops: 65 flushes of 4 entries
        for (int f = 0; f < 65; f++) begin
            for (int p = 0; p < 4; p++)
                cycle(0, 1, 16'(f * 4 + p), 16'hC000 + 16'(p), 0);
            cycle(1, 0, 16'h0000, 16'h0000, 0);
            $display("flush %0d: drops=%0d", f, bus.flush_drops);
        end
        check("drops_saturated", bus.flush_drops, 8'hFF);
        cycle(0, 0, 16'h0000, 16'h0000, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of instruction entries; legal values 2, 4 and 8.
REQ-002 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low; clock clk.
REQ-004 SHALL have port flush  input  1  branch/return redirect; discard all queued instructions.
REQ-005 SHALL have port if_valid  input  1  fetch stage presents a valid instruction this cycle.
REQ-006 SHALL have port if_pc  input  16  word address of the presented instruction.
REQ-007 SHALL have port if_instr  input  16  presented instruction; may be X when if_valid=0.
REQ-008 SHALL have port if_ready  output  1  queue accepts a push this cycle.
REQ-009 SHALL have port id_ready  input  1  decode stage consumes the head entry this cycle.
REQ-010 SHALL have port id_valid  output  1  head entry valid.
REQ-011 SHALL have port id_pc  output  16  head entry PC.
REQ-012 SHALL have port id_pc_next  output  16  head entry PC + 1, modulo 2^16.
REQ-013 SHALL have port id_instr  output  16  head entry instruction.
REQ-014 SHALL have port occupancy  output  4  number of valid entries, 0..DEPTH.
REQ-015 SHALL have port flush_drops  output  8  saturating count of entries discarded by flush.

Function
REQ-016 SHALL be a circular FIFO with log2(DEPTH)-bit write/read pointers that wrap DEPTH-1 -> 0 and a count register 0..DEPTH.
REQ-017 SHALL push (store if_pc, if_instr at write pointer, advance it) when if_valid & if_ready at a rising edge.
REQ-018 SHALL pop (advance read pointer) when id_valid & id_ready at a rising edge.
REQ-019 SHALL drive if_ready = rst & !flush & (count < DEPTH), from registered count only; no pass-through when full, even if a pop occurs the same cycle.
REQ-020 SHALL drive id_valid = rst & !flush & (count > 0); no empty-queue bypass, minimum push-to-id_valid latency 1 cycle.
REQ-021 SHALL drive id_pc, id_instr from the head entry when id_valid=1, and 16'h0000 for id_pc, id_instr, id_pc_next when id_valid=0 (never X).
REQ-022 SHALL leave count unchanged on simultaneous push and pop, increment on push only, decrement on pop only.
REQ-023 SHALL never write storage or move the write pointer when if_valid=0, regardless of if_instr content.
REQ-024 SHALL, when flush=1 at a rising edge, set count=0, write pointer=read pointer=0, and ignore any push or pop that cycle (flush priority).
REQ-025 SHALL add the pre-flush count to flush_drops on each flush, saturating at 8'hFF.
REQ-026 SHALL drive occupancy equal to the count register.

Reset
REQ-027 SHALL, when rst=0 at a rising edge, clear count, both pointers and flush_drops to 0; reset has priority over flush, push and pop.
REQ-028 SHALL hold if_ready=0, id_valid=0, id_pc=id_instr=id_pc_next=16'h0000, occupancy=0 while rst=0 and on the first cycle after release.
REQ-029 SHALL discard all queued entries on reset asserted mid-operation; storage contents need not be cleared.

Verification
REQ-030 Single push: push pc=16'h0010, instr=16'hA5A5 into empty queue -> next cycle id_valid=1, id_pc=16'h0010, id_pc_next=16'h0011, id_instr=16'hA5A5, occupancy=1.
REQ-031 Fill/full: DEPTH=4, id_ready=0, push pc 0..4 on 5 cycles -> if_ready=0 after 4th push, occupancy=4, 5th push ignored; pop 4 -> PCs 0,1,2,3 in order.
REQ-032 Full with simultaneous pop: occupancy=4, if_valid=1, id_ready=1 -> pop only, occupancy=3; push accepted next cycle.
REQ-033 Wrap-around: 10 push/pop pairs with pc 16'hFFF8..16'h0001 -> outputs in order, id_pc_next of 16'hFFFF is 16'h0000, occupancy constant.
REQ-034 Flush: occupancy=3, flush=1 with if_valid=1, id_ready=1 -> that cycle id_valid=if_ready=0; next cycle occupancy=0, flush_drops=3, pushed entry absent.
REQ-035 Reset mid-operation: occupancy=2, rst=0 one cycle with if_valid=1 -> occupancy=0, flush_drops=0, id_instr=16'h0000, if_ready=0 until one cycle after release.
